// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg: shared definitions for the CPU instruction sequencer.
//   - DATA_W          : width of memory data and instructions
//   - OP_*            : opcode values carried in ir[7:4]
//   - state_e         : sequencer state encoding
//   - ALU_*           : ALU function codes carried in ir[2:0] (shared with ALU)
//   - op_class_e      : how the sequencer treats an opcode after decode
//   - op_class()      : opcode -> class helper used by the combinational decode
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 8;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_STB = 4'h4;
    localparam logic [3:0] OP_LIM = 4'h5;
    localparam logic [3:0] OP_ALU = 4'h6;
    localparam logic [3:0] OP_MAB = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOT = 3'd5;
    localparam logic [2:0] ALU_SHL = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEMACC = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CLS_EXEC    = 2'd0,
        CLS_MEM     = 2'd1,
        CLS_HALT    = 2'd2,
        CLS_ILLEGAL = 2'd3
    } op_class_e;

    // Classify an opcode by the state the sequencer enters after DECODE.
    function automatic op_class_e op_class(input logic [3:0] op);
        op_class_e cls;
        case (op)
            OP_NOP, OP_ALU, OP_MAB, OP_JMP, OP_JZ:  cls = CLS_EXEC;
            OP_LDA, OP_LDB, OP_STA, OP_STB, OP_LIM: cls = CLS_MEM;
            OP_HLT:                                 cls = CLS_HALT;
            default:                                cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_if: memory-side bus of the instruction sequencer.
//   mem_rdata : read data, valid when mem_ack=1
//   mem_ack   : access completes this cycle
//   mem_rd    : read strobe, held until ack
//   mem_wr    : write strobe, held until ack
//   addr_sel  : 0 -> address from rP, 1 -> address from rM
//   wdata_sel : 0 -> write data from rA, 1 -> write data from rB
// master = sequencer, slave = memory/datapath side.
// ---------------------------------------------------------------------------
interface cpu_ctrl_if;
    import cpu_pkg::*;

    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_rd;
    logic              mem_wr;
    logic              addr_sel;
    logic              wdata_sel;

    modport master (
        input  mem_rdata, mem_ack,
        output mem_rd, mem_wr, addr_sel, wdata_sel
    );

    modport slave (
        output mem_rdata, mem_ack,
        input  mem_rd, mem_wr, addr_sel, wdata_sel
    );
endinterface

// File: rtl/cpu_ctrl_wdog.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_wdog: bus-wait watchdog.
//   clk, rst : clock, asynchronous active-low reset
//   busy     : a memory strobe is currently high
//   ack      : memory acknowledges this cycle
//   timeout  : this is the WAIT_LIMIT-th waiting cycle and no ack arrived
// The counter clears whenever no access is pending or an access completes,
// which covers every entry into FETCH and MEMACC. WAIT_LIMIT=0 disables it.
// ---------------------------------------------------------------------------
module cpu_ctrl_wdog #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic timeout
);
    localparam int            CW     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic          WD_EN  = (WAIT_LIMIT > 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] LIM_M1 = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_r;

    // Count waiting cycles of the current access, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (!busy || ack) begin
            cnt_r <= '0;
        end else if (cnt_r != LIM_M1) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // An ack in the limit cycle wins over the timeout.
    assign timeout = WD_EN & busy & ~ack & (cnt_r == LIM_M1);

endmodule

// File: rtl/cpu_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_ctrl: instruction sequencer in front of the CPU register block.
// Fetches an instruction at rP, decodes ir[7:4], and sequences the register
// write enables, PC control, memory strobes and datapath selects.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : memory bus (cpu_ctrl_if.master)
//   rA_zero   : rA_out == 0 from the datapath
//   a_src     : 0 -> rA_in = mem_rdata, 1 -> rA_in = ALU result
//   alu_op    : ALU function, always ir[2:0]
//   rA_we, rB_we, rM_we : register write enables (single-cycle pulses)
//   rP_inc, rP_load     : PC increment / load from rM (never together)
//   ir        : instruction register
//   halted    : core stopped (sticky until reset)
//   err       : halt caused by illegal opcode or bus timeout
// Parameters: WAIT_LIMIT (0 = no watchdog), HALT_ON_ILLEGAL (0 = illegal is NOP)
// ---------------------------------------------------------------------------
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int WAIT_LIMIT      = 0,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    cpu_ctrl_if.master        bus,
    input  logic              rA_zero,
    output logic              a_src,
    output logic [2:0]        alu_op,
    output logic              rA_we,
    output logic              rB_we,
    output logic              rM_we,
    output logic              rP_inc,
    output logic              rP_load,
    output logic [DATA_W-1:0] ir,
    output logic              halted,
    output logic              err
);

    state_e            state_r;
    logic [DATA_W-1:0] ir_r;
    logic              mem_rd_r;
    logic              mem_wr_r;
    logic              addr_sel_r;
    logic              wdata_sel_r;
    logic              a_src_r;
    logic              halted_r;
    logic              err_r;

    logic [3:0]        opcode_s;
    op_class_e         op_cls_s;
    logic              busy_s;
    logic              ack_s;
    logic              timeout_s;
    logic              go_halt_s;
    logic              halt_err_s;
    logic              rA_we_s;
    logic              rB_we_s;
    logic              rM_we_s;
    logic              rP_inc_s;
    logic              rP_load_s;

    cpu_ctrl_wdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy_s),
        .ack     (bus.mem_ack),
        .timeout (timeout_s)
    );

    // Instruction decode and access qualification; ack only counts while a strobe is up.
    always_comb begin
        opcode_s = ir_r[7:4];
        op_cls_s = op_class(opcode_s);
        busy_s   = mem_rd_r | mem_wr_r;
        ack_s    = busy_s & bus.mem_ack;
    end

    // Decide whether this cycle ends in HALT, and whether that halt is an error.
    always_comb begin
        go_halt_s  = 1'b0;
        halt_err_s = 1'b0;
        if (timeout_s) begin
            go_halt_s  = 1'b1;
            halt_err_s = 1'b1;
        end else if (state_r == ST_DECODE) begin
            case (op_cls_s)
                CLS_HALT: begin
                    go_halt_s = 1'b1;
                end
                CLS_ILLEGAL: begin
                    go_halt_s  = HALT_ON_ILLEGAL;
                    halt_err_s = HALT_ON_ILLEGAL;
                end
                default: begin
                    go_halt_s = 1'b0;
                end
            endcase
        end else begin
            go_halt_s = 1'b0;
        end
    end

    // Sequencer FSM with registered strobes, selects and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_FETCH;
            ir_r        <= 8'h00;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            addr_sel_r  <= 1'b0;
            wdata_sel_r <= 1'b0;
            a_src_r     <= 1'b0;
            halted_r    <= 1'b0;
            err_r       <= 1'b0;
        end else if (go_halt_s) begin
            state_r     <= ST_HALT;
            ir_r        <= 8'h00;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            addr_sel_r  <= 1'b0;
            wdata_sel_r <= 1'b0;
            a_src_r     <= 1'b0;
            halted_r    <= 1'b1;
            err_r       <= err_r | halt_err_s;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    // Strobes reset low, so the first fetch after reset raises mem_rd first.
                    if (!mem_rd_r) begin
                        mem_rd_r <= 1'b1;
                    end else if (ack_s) begin
                        ir_r     <= bus.mem_rdata;
                        mem_rd_r <= 1'b0;
                        state_r  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (op_cls_s)
                        CLS_EXEC: begin
                            state_r <= ST_EXEC;
                            a_src_r <= (opcode_s == OP_ALU);
                        end
                        CLS_MEM: begin
                            state_r     <= ST_MEMACC;
                            addr_sel_r  <= (opcode_s != OP_LIM);
                            mem_rd_r    <= (opcode_s inside {OP_LDA, OP_LDB, OP_LIM});
                            mem_wr_r    <= (opcode_s inside {OP_STA, OP_STB});
                            wdata_sel_r <= (opcode_s == OP_STB);
                        end
                        default: begin
                            // Only a non-halting illegal opcode reaches here: behave as NOP.
                            state_r  <= ST_FETCH;
                            mem_rd_r <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC: begin
                    state_r  <= ST_FETCH;
                    a_src_r  <= 1'b0;
                    mem_rd_r <= 1'b1;
                end
                ST_MEMACC: begin
                    if (ack_s) begin
                        state_r     <= ST_FETCH;
                        mem_rd_r    <= 1'b1;
                        mem_wr_r    <= 1'b0;
                        addr_sel_r  <= 1'b0;
                        wdata_sel_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    // Corrupted state encoding: stop safely and flag it.
                    state_r     <= ST_HALT;
                    mem_rd_r    <= 1'b0;
                    mem_wr_r    <= 1'b0;
                    addr_sel_r  <= 1'b0;
                    wdata_sel_r <= 1'b0;
                    a_src_r     <= 1'b0;
                    halted_r    <= 1'b1;
                    err_r       <= 1'b1;
                end
            endcase
        end
    end

    // Enable pulses must coincide with the ack cycle, so they come from the
    // registered state and instruction qualified by the live ack / rA_zero.
    always_comb begin
        rA_we_s   = 1'b0;
        rB_we_s   = 1'b0;
        rM_we_s   = 1'b0;
        rP_inc_s  = 1'b0;
        rP_load_s = 1'b0;
        case (state_r)
            ST_FETCH: begin
                rP_inc_s = ack_s;
            end
            ST_EXEC: begin
                case (opcode_s)
                    OP_ALU:  rA_we_s   = 1'b1;
                    OP_MAB:  rB_we_s   = 1'b1;
                    OP_JMP:  rP_load_s = 1'b1;
                    OP_JZ:   rP_load_s = rA_zero;
                    default: rP_load_s = 1'b0;
                endcase
            end
            ST_MEMACC: begin
                if (ack_s) begin
                    case (opcode_s)
                        OP_LDA:  rA_we_s = 1'b1;
                        OP_LDB:  rB_we_s = 1'b1;
                        OP_LIM: begin
                            rM_we_s  = 1'b1;
                            rP_inc_s = 1'b1;
                        end
                        default: rA_we_s = 1'b0;
                    endcase
                end else begin
                    rA_we_s = 1'b0;
                end
            end
            default: begin
                rA_we_s = 1'b0;
            end
        endcase
    end

    assign bus.mem_rd    = mem_rd_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.addr_sel  = addr_sel_r;
    assign bus.wdata_sel = wdata_sel_r;
    assign a_src         = a_src_r;
    assign alu_op        = ir_r[2:0];
    assign rA_we         = rA_we_s;
    assign rB_we         = rB_we_s;
    assign rM_we         = rM_we_s;
    assign rP_inc        = rP_inc_s;
    assign rP_load       = rP_load_s;
    assign ir            = ir_r;
    assign halted        = halted_r;
    assign err           = err_r;

endmodule

// File: tb/tb_cpu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl: directed self-checking bench for cpu_ctrl.
// dut0: WAIT_LIMIT=8, HALT_ON_ILLEGAL=1. dut1: WAIT_LIMIT=0, HALT_ON_ILLEGAL=0.
// Inputs change 2 time units after the rising edge, outputs are compared
// 1 unit later, well clear of the next rising edge.
// Output vector bit order:
// {mem_rd, mem_wr, addr_sel, wdata_sel, a_src, rA_we, rB_we, rM_we,
//  rP_inc, rP_load, halted, err}
// ---------------------------------------------------------------------------
module tb_cpu_ctrl;

    localparam logic [11:0] Z    = 12'h000;
    localparam logic [11:0] RD   = 12'h800;
    localparam logic [11:0] WR   = 12'h400;
    localparam logic [11:0] AS   = 12'h200;
    localparam logic [11:0] WS   = 12'h100;
    localparam logic [11:0] ASRC = 12'h080;
    localparam logic [11:0] AWE  = 12'h040;
    localparam logic [11:0] BWE  = 12'h020;
    localparam logic [11:0] MWE  = 12'h010;
    localparam logic [11:0] INC  = 12'h008;
    localparam logic [11:0] LD   = 12'h004;
    localparam logic [11:0] HLT  = 12'h002;
    localparam logic [11:0] ERR  = 12'h001;

    logic clk;
    logic rst;
    logic rA_zero;

    cpu_ctrl_if bif0 ();
    cpu_ctrl_if bif1 ();

    logic       a_src0, rA_we0, rB_we0, rM_we0, rP_inc0, rP_load0, halted0, err0;
    logic [2:0] alu_op0;
    logic [7:0] ir0;
    logic       a_src1, rA_we1, rB_we1, rM_we1, rP_inc1, rP_load1, halted1, err1;
    logic [2:0] alu_op1;
    logic [7:0] ir1;
    logic [11:0] o0;
    logic [11:0] o1;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_ctrl #(.WAIT_LIMIT(8), .HALT_ON_ILLEGAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(bif0), .rA_zero(rA_zero),
        .a_src(a_src0), .alu_op(alu_op0), .rA_we(rA_we0), .rB_we(rB_we0),
        .rM_we(rM_we0), .rP_inc(rP_inc0), .rP_load(rP_load0), .ir(ir0),
        .halted(halted0), .err(err0)
    );

    cpu_ctrl #(.WAIT_LIMIT(0), .HALT_ON_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(bif1), .rA_zero(rA_zero),
        .a_src(a_src1), .alu_op(alu_op1), .rA_we(rA_we1), .rB_we(rB_we1),
        .rM_we(rM_we1), .rP_inc(rP_inc1), .rP_load(rP_load1), .ir(ir1),
        .halted(halted1), .err(err1)
    );

    assign o0 = {bif0.mem_rd, bif0.mem_wr, bif0.addr_sel, bif0.wdata_sel, a_src0,
                 rA_we0, rB_we0, rM_we0, rP_inc0, rP_load0, halted0, err0};
    assign o1 = {bif1.mem_rd, bif1.mem_wr, bif1.addr_sel, bif1.wdata_sel, a_src1,
                 rA_we1, rB_we1, rM_we1, rP_inc1, rP_load1, halted1, err1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive the selected DUT's memory inputs, then compare its outputs.
    task automatic cyc(input int sel, input logic ack, input logic [7:0] rdata,
                       input logic rz, input string tag, input logic [11:0] exp);
        @(posedge clk);
        #2;
        rA_zero = rz;
        if (sel == 0) begin
            bif0.mem_ack   = ack;
            bif0.mem_rdata = rdata;
        end else begin
            bif1.mem_ack   = ack;
            bif1.mem_rdata = rdata;
        end
        #1;
        if (sel == 0) chk_eq(tag, o0, exp);
        else          chk_eq(tag, o1, exp);
    endtask

    // Fetch + decode of a non-memory instruction, then its EXEC cycle.
    task automatic run_exec(input logic [7:0] instr, input logic rz,
                            input string tag, input logic [11:0] exp);
        cyc(0, 1'b1, instr, 1'b0, {tag, "_fetch"}, RD | INC);
        cyc(0, 1'b0, 8'h00, 1'b0, {tag, "_decode"}, Z);
        cyc(0, 1'b0, 8'h00, rz, {tag, "_exec"}, exp);
    endtask

    // Asynchronous reset assertion between edges, then release.
    task automatic async_reset(input string tag);
        #1;
        rst = 1'b0;
        #1;
        chk_eq({tag, "_outs"}, o0, Z);
        chk_eq({tag, "_ir"}, ir0, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        rA_zero        = 1'b0;
        bif0.mem_ack   = 1'b0;
        bif0.mem_rdata = 8'h00;
        bif1.mem_ack   = 1'b0;
        bif1.mem_rdata = 8'h00;
        #3;
        chk_eq("reset_outs", o0, Z);
        chk_eq("reset_ir", ir0, 8'h00);
        chk_eq("reset_alu_op", alu_op0, 3'd0);
        #9;
        rst = 1'b1;

        // NOP stream with immediate ack: rP_inc every third cycle only.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1'b1, 8'h00, 1'b0, "nop_fetch", RD | INC);
            cyc(0, 1'b1, 8'h00, 1'b0, "nop_decode", Z);
            cyc(0, 1'b1, 8'h00, 1'b0, "nop_exec", Z);
        end

        // LIM 0x20 then LDA with mem[0x20]=0x5A.
        cyc(0, 1'b1, 8'h50, 1'b0, "lim_fetch", RD | INC);
        cyc(0, 1'b0, 8'h00, 1'b0, "lim_decode", Z);
        chk_eq("lim_ir", ir0, 8'h50);
        cyc(0, 1'b1, 8'h20, 1'b0, "lim_acc", RD | MWE | INC);
        cyc(0, 1'b1, 8'h10, 1'b0, "lda_fetch", RD | INC);
        cyc(0, 1'b0, 8'h00, 1'b0, "lda_decode", Z);
        cyc(0, 1'b1, 8'h5A, 1'b0, "lda_acc", RD | AS | AWE);

        // STB with ack delayed 4 cycles: strobe and selects held 5 cycles.
        cyc(0, 1'b1, 8'h40, 1'b0, "stb_fetch", RD | INC);
        cyc(0, 1'b0, 8'h00, 1'b0, "stb_decode", Z);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1'b0, 8'h00, 1'b0, "stb_wait", WR | AS | WS);
        end
        cyc(0, 1'b1, 8'h00, 1'b0, "stb_ack", WR | AS | WS);
        cyc(0, 1'b0, 8'h00, 1'b0, "stb_refetch", RD);

        // Branches, ALU and register move.
        run_exec(8'h90, 1'b1, "jz_taken", LD);
        run_exec(8'h90, 1'b0, "jz_not_taken", Z);
        run_exec(8'h80, 1'b0, "jmp", LD);
        run_exec(8'h63, 1'b0, "alu", ASRC | AWE);
        chk_eq("alu_op", alu_op0, 3'd3);
        run_exec(8'h70, 1'b0, "mab", BWE);

        // Illegal opcode halts dut0 with err; nothing moves afterwards.
        cyc(0, 1'b1, 8'hA0, 1'b0, "ill_fetch", RD | INC);
        cyc(0, 1'b1, 8'h00, 1'b0, "ill_decode", Z);
        cyc(0, 1'b1, 8'h00, 1'b0, "ill_halt", HLT | ERR);
        cyc(0, 1'b1, 8'h00, 1'b0, "ill_sticky", HLT | ERR);
        chk_eq("ill_ir", ir0, 8'h00);

        // dut1 treats the illegal opcode as NOP, then halts cleanly on HLT.
        cyc(1, 1'b1, 8'hA0, 1'b0, "ill1_fetch", RD | INC);
        cyc(1, 1'b0, 8'h00, 1'b0, "ill1_decode", Z);
        cyc(1, 1'b0, 8'h00, 1'b0, "ill1_refetch", RD);
        cyc(1, 1'b1, 8'hF0, 1'b0, "hlt1_fetch", RD | INC);
        cyc(1, 1'b0, 8'h00, 1'b0, "hlt1_decode", Z);
        cyc(1, 1'b1, 8'h00, 1'b0, "hlt1_halt", HLT);

        // Watchdog: ack tied low, mem_rd held exactly 8 cycles.
        bif0.mem_ack = 1'b0;
        async_reset("halt_clear");
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1'b0, 8'h00, 1'b0, "wd_wait", RD);
        end
        cyc(0, 1'b0, 8'h00, 1'b0, "wd_timeout", HLT | ERR);

        // Reset in the middle of a pending fetch drops the strobe at once.
        async_reset("wd_restart");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1'b0, 8'h00, 1'b0, "mid_wait", RD);
        end
        async_reset("mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
